ftdi_tx_arbiter: RTL

- Shares the single FTDI transmit byte channel between two sources:
  - register-read responses from the command parser;
  - the continuous 16-bit ADC sample stream.
- Responses go out as tagged 2-byte frames.
- Samples go out as fixed-length packets with a sync byte and a sequence byte.
- Responses are only inserted at packet boundaries, so the host can parse the stream unambiguously.

---
 rtl/ftdi_tx_arbiter_pkg.sv | 19 +
 rtl/ftdi_tx_arbiter.sv | 132 +++++++++++++
 2 files changed

// File: rtl/ftdi_tx_arbiter_pkg.sv
// Shared definitions for the FTDI transmit arbiter: FSM encoding and the
// framing bytes the host software must agree on.
package ftdi_tx_arbiter_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RESP_TAG  = 3'd1,
    S_RESP_DATA = 3'd2,
    S_SYNC      = 3'd3,
    S_SEQ       = 3'd4,
    S_SMP_WAIT  = 3'd5,
    S_SMP_LO    = 3'd6,
    S_SMP_HI    = 3'd7
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h5A;
  localparam logic [7:0] RESP_TAG_DEFAULT  = 8'hA5;

endpackage

// File: rtl/ftdi_tx_arbiter.sv
// Multiplexes register-read responses and the ADC sample stream onto the
// single FTDI transmit byte channel; responses only go out between packets.
module ftdi_tx_arbiter
  import ftdi_tx_arbiter_pkg::*;
#(
  parameter int         PKT_SAMPLES = 256,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT,
  parameter logic [7:0] RESP_TAG    = RESP_TAG_DEFAULT
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic [7:0]  resp_data,
  input  logic        resp_valid,
  input  logic [15:0] smp_data,
  input  logic        smp_valid,
  output logic        smp_ready,
  input  logic        stream_en,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        resp_overflow,
  input  logic        ovf_clear,
  output logic [7:0]  seq
);

  // Handshakes: a byte transfers on a clock edge where tx_valid && tx_ready;
  // a sample transfers where smp_valid && smp_ready. Once tx_valid is high,
  // tx_data is held until that transfer happens.

  localparam logic [7:0] LAST_SMP = 8'(PKT_SAMPLES - 1);

  state_t      state, state_nxt;
  logic [8:0]  slot;            // {pending, byte}
  logic [7:0]  resp_byte;
  logic [7:0]  smp_hi;
  logic [7:0]  count;
  logic        tx_valid_nxt;
  logic [7:0]  tx_data_nxt;
  logic        hs;
  logic        slot_take;
  logic        ovf_set;

  assign hs        = tx_valid && tx_ready;
  assign slot_take = (state == S_IDLE) && slot[8];
  assign ovf_set   = resp_valid && slot[8] && !slot_take;
  assign smp_ready = (state == S_SMP_WAIT);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (slot[8])                     state_nxt = S_RESP_TAG;
        else if (stream_en && smp_valid) state_nxt = S_SYNC;
      end
      S_RESP_TAG:  if (hs) state_nxt = S_RESP_DATA;
      S_RESP_DATA: if (hs) state_nxt = S_IDLE;
      S_SYNC:      if (hs) state_nxt = S_SEQ;
      S_SEQ:       if (hs) state_nxt = S_SMP_WAIT;
      S_SMP_WAIT:  if (smp_valid) state_nxt = S_SMP_LO;
      S_SMP_LO:    if (hs) state_nxt = S_SMP_HI;
      S_SMP_HI: begin
        if (hs) state_nxt = (count == LAST_SMP) ? S_IDLE : S_SMP_WAIT;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // The output byte is loaded only when entering a new state, so a stalled
  // byte stays put until its handshake.
  always_comb begin
    tx_valid_nxt = tx_valid;
    tx_data_nxt  = tx_data;
    if (state_nxt != state) begin
      tx_valid_nxt = 1'b1;
      case (state_nxt)
        S_RESP_TAG:  tx_data_nxt = RESP_TAG;
        S_RESP_DATA: tx_data_nxt = resp_byte;
        S_SYNC:      tx_data_nxt = SYNC_BYTE;
        S_SEQ:       tx_data_nxt = seq;
        S_SMP_LO:    tx_data_nxt = smp_data[7:0];
        S_SMP_HI:    tx_data_nxt = smp_hi;
        default:     tx_valid_nxt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state    <= S_IDLE;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      state    <= state_nxt;
      tx_valid <= tx_valid_nxt;
      tx_data  <= tx_data_nxt;
    end
  end

  // Response slot: a strobe arriving as the slot drains is still captured.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      slot          <= 9'h000;
      resp_byte     <= 8'h00;
      resp_overflow <= 1'b0;
    end else begin
      if (slot_take) resp_byte <= slot[7:0];
      if (resp_valid && (!slot[8] || slot_take)) slot <= {1'b1, resp_data};
      else if (slot_take)                        slot[8] <= 1'b0;
      if (ovf_set)        resp_overflow <= 1'b1;
      else if (ovf_clear) resp_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      smp_hi <= 8'h00;
      count  <= 8'h00;
      seq    <= 8'h00;
    end else begin
      if (state == S_SMP_WAIT && smp_valid) smp_hi <= smp_data[15:8];
      if (state == S_SMP_HI && hs) begin
        if (count == LAST_SMP) begin
          count <= 8'h00;
          seq   <= seq + 8'd1;
        end else begin
          count <= count + 8'd1;
        end
      end
    end
  end

endmodule
